// File: rtl/rsa_crt_decrypt.sv
// rsa_crt_decrypt: sequential RSA-CRT decryption (extended Euclid, square-and-multiply, Garner) with start/done handshake
module rsa_crt_decrypt #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   p,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [W-1:0]   qinv,
  output logic [2*W-1:0] m
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] THREE = {{(W-2){1'b0}}, 2'b11};
  typedef enum logic [2:0] {IDLE, LOAD, INV, EXP_P, EXP_Q, CRT_H, CRT_M, DONE} state_t;
  state_t state;
  logic [W-1:0] rp, rq, rc, rd, cq, dq, a, b, r, base, e, m1, m2, h;
  logic signed [W:0] t0, t1, nt0, nt1, t0p;
  logic [W-1:0] n, bs, quo, na, nb, r_nx, m2p, diff, ps, qs, pd, qd, dp, cp;
  logic [2*W-1:0] r_prod, b_prod, h_prod;
  logic load_err, e_last;
  always_comb begin
    load_err = rp < THREE || rq < THREE || rp == rq;
    ps = load_err ? ONE : rp;
    qs = load_err ? ONE : rq;
    pd = load_err ? ONE : rp - ONE;
    qd = load_err ? ONE : rq - ONE;
    dp = rd % pd;
    cp = rc % ps;
    bs = b == '0 ? ONE : b;
    quo = a / bs;
    na = b == '0 ? a : b;
    nb = b == '0 ? '0 : a % bs;
    nt0 = b == '0 ? t0 : t1;
    nt1 = b == '0 ? t1 : t0 - $signed({1'b0, quo}) * t1;
    t0p = nt0[W] ? nt0 + $signed({1'b0, rp}) : nt0;
    n = state == EXP_Q ? rq : rp;
    r_prod = ({{W{1'b0}}, r} * {{W{1'b0}}, base}) % {{W{1'b0}}, n};
    b_prod = ({{W{1'b0}}, base} * {{W{1'b0}}, base}) % {{W{1'b0}}, n};
    r_nx = e[0] ? r_prod[W-1:0] : r;
    e_last = e[W-1:1] == '0;
    m2p = m2 % rp;
    diff = m1 >= m2p ? m1 - m2p : rp - m2p + m1;
    h_prod = ({{W{1'b0}}, qinv} * {{W{1'b0}}, diff}) % {{W{1'b0}}, rp};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      qinv <= '0;
      m <= '0;
      {rp, rq, rc, rd, cq, dq, a, b, r, base, e, m1, m2, h} <= '0;
      t0 <= '0;
      t1 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          {rp, rq, rc, rd} <= {p, q, c, d};
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          a <= rp;
          b <= rq % ps;
          t0 <= '0;
          t1 <= {{W{1'b0}}, 1'b1};
          r <= ONE;
          base <= cp;
          e <= dp;
          cq <= rc % qs;
          dq <= rd % qd;
          if (load_err) begin
            {err, qinv, m, done} <= {1'b1, {W{1'b0}}, {(2*W){1'b0}}, 1'b1};
            state <= DONE;
          end else state <= INV;
        end
        INV: begin
          a <= na;
          b <= nb;
          t0 <= nt0;
          t1 <= nt1;
          if (nb == '0 && na != ONE) begin
            {err, qinv, m, done} <= {1'b1, {W{1'b0}}, {(2*W){1'b0}}, 1'b1};
            state <= DONE;
          end else if (nb == '0) begin
            err <= 1'b0;
            qinv <= t0p[W-1:0];
            state <= EXP_P;
          end
        end
        EXP_P: begin
          r <= r_nx;
          base <= b_prod[W-1:0];
          e <= e >> 1;
          if (e_last) begin
            m1 <= r_nx;
            r <= ONE;
            base <= cq;
            e <= dq;
            state <= EXP_Q;
          end
        end
        EXP_Q: begin
          r <= r_nx;
          base <= b_prod[W-1:0];
          e <= e >> 1;
          if (e_last) begin
            m2 <= r_nx;
            state <= CRT_H;
          end
        end
        CRT_H: begin
          h <= h_prod[W-1:0];
          state <= CRT_M;
        end
        CRT_M: begin
          m <= {{W{1'b0}}, m2} + {{W{1'b0}}, h} * {{W{1'b0}}, rq};
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
